// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: call-bit indices, grant ids
// and FSM state encodings.
package sdram_port_arbiter_pkg;

  localparam int CALL_GREAD = 2;
  localparam int CALL_WRITE = 1;
  localparam int CALL_READ  = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CAM  = 2'd2,
    GNT_AUX  = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // One-hot controller call for a granted port; zero when nobody is granted.
  function automatic logic [2:0] call_bit(input grant_e g);
    logic [2:0] v;
    v = 3'b000;
    case (g)
      GNT_DISP: v[CALL_GREAD] = 1'b1;
      GNT_CAM:  v[CALL_WRITE] = 1'b1;
      GNT_AUX:  v[CALL_READ]  = 1'b1;
      default:  v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller-side bus of the SDRAM port arbiter. The master
// modport is the arbiter's view; slave is the requesters plus controller.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);

  logic              disp_req;
  logic              cam_req;
  logic              aux_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] cam_addr;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] cam_wdata;
  logic              disp_done;
  logic              cam_done;
  logic              aux_done;
  logic [DATA_W-1:0] aux_rdata;
  logic [2:0]        mem_call;
  logic [2:0]        mem_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [1:0]        grant_id;

  modport master (
    input  disp_req, cam_req, aux_req, disp_addr, cam_addr, aux_addr,
           cam_wdata, mem_done, mem_rdata,
    output disp_done, cam_done, aux_done, aux_rdata, mem_call, mem_addr,
           mem_wdata, busy, grant_id
  );

  modport slave (
    output disp_req, cam_req, aux_req, disp_addr, cam_addr, aux_addr,
           cam_wdata, mem_done, mem_rdata,
    input  disp_done, cam_done, aux_done, aux_rdata, mem_call, mem_addr,
           mem_wdata, busy, grant_id
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: fixed priority disp > cam > aux, overridden
// by a saturated starvation counter (cam's override beats aux's).
module sdram_arb_pick
  import sdram_port_arbiter_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             disp_req,
  input  logic             cam_req,
  input  logic             aux_req,
  input  logic [CNT_W-1:0] starve_cam,
  input  logic [CNT_W-1:0] starve_aux,
  output grant_e           winner
);

  always_comb begin
    winner = GNT_NONE;
    if (cam_req && starve_cam == CNT_W'(STARVE_MAX)) begin
      winner = GNT_CAM;
    end else if (aux_req && starve_aux == CNT_W'(STARVE_MAX)) begin
      winner = GNT_AUX;
    end else if (disp_req) begin
      winner = GNT_DISP;
    end else if (cam_req) begin
      winner = GNT_CAM;
    end else if (aux_req) begin
      winner = GNT_AUX;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM command controller between display, camera and aux ports:
// arbitrates in IDLE, holds one call bit until its done, returns a port done.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_port_arbiter_if.master bus
);

  import sdram_port_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d, pick;
  logic [2:0]        call_q, call_d;
  logic [2:0]        done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  starve_cam_q, starve_cam_d;
  logic [CNT_W-1:0]  starve_aux_q, starve_aux_d;

  sdram_arb_pick #(
    .CNT_W      (CNT_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .disp_req   (bus.disp_req),
    .cam_req    (bus.cam_req),
    .aux_req    (bus.aux_req),
    .starve_cam (starve_cam_q),
    .starve_aux (starve_aux_q),
    .winner     (pick)
  );

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(STARVE_MAX)) ? cnt : cnt + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    call_d       = call_q;
    done_d       = 3'b000;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    starve_cam_d = starve_cam_q;
    starve_aux_d = starve_aux_q;

    case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d = pick;
          state_d = ST_ISSUE;
          case (pick)
            GNT_DISP: addr_d = bus.disp_addr;
            GNT_CAM: begin
              addr_d  = bus.cam_addr;
              wdata_d = bus.cam_wdata;
            end
            GNT_AUX:  addr_d = bus.aux_addr;
            default:  addr_d = addr_q;
          endcase
          // A pending loser ages; a winner or an idle port starts over.
          starve_cam_d = (bus.cam_req && pick != GNT_CAM) ? bump(starve_cam_q) : '0;
          starve_aux_d = (bus.aux_req && pick != GNT_AUX) ? bump(starve_aux_q) : '0;
        end
      end
      ST_ISSUE: begin
        call_d  = call_bit(grant_q);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Only the done bit matching our own call ends the transaction.
        if ((bus.mem_done & call_q) != 3'b000) begin
          call_d  = 3'b000;
          done_d  = call_q;
          state_d = ST_ACK;
          if (grant_q == GNT_AUX) begin
            rdata_d = bus.mem_rdata;
          end
        end
      end
      ST_ACK: begin
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      call_q       <= 3'b000;
      done_q       <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      starve_cam_q <= '0;
      starve_aux_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      call_q       <= call_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      starve_cam_q <= starve_cam_d;
      starve_aux_q <= starve_aux_d;
    end
  end

  assign bus.mem_call  = call_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.aux_rdata = rdata_q;
  assign bus.disp_done = done_q[CALL_GREAD];
  assign bus.cam_done  = done_q[CALL_WRITE];
  assign bus.aux_done  = done_q[CALL_READ];
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed plus randomized bench for sdram_port_arbiter, checked against a
// transaction-level model of the arbitration and starvation rules.
module tb_sdram_port_arbiter;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state.
  int                starve_cam_m = 0;
  int                starve_aux_m = 0;
  logic [DATA_W-1:0] wdata_m      = '0;
  logic [DATA_W-1:0] rdata_m      = '0;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  sdram_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] dones();
    return {bus_if.disp_done, bus_if.cam_done, bus_if.aux_done};
  endfunction

  // Winner from the rules: saturated cam, then saturated aux, then disp>cam>aux.
  function automatic int model_pick(input logic d, input logic c, input logic a);
    if (c && starve_cam_m == STARVE_MAX) return 2;
    if (a && starve_aux_m == STARVE_MAX) return 3;
    if (d) return 1;
    if (c) return 2;
    if (a) return 3;
    return 0;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_call"},  64'(bus_if.mem_call),  64'd0);
    check({pfx, "_dones"},     64'(dones()),          64'd0);
    check({pfx, "_busy"},      64'(bus_if.busy),      64'd0);
    check({pfx, "_grant_id"},  64'(bus_if.grant_id),  64'd0);
    check({pfx, "_aux_rdata"}, 64'(bus_if.aux_rdata), 64'd0);
    check({pfx, "_mem_addr"},  64'(bus_if.mem_addr),  64'd0);
    check({pfx, "_mem_wdata"}, 64'(bus_if.mem_wdata), 64'd0);
  endtask

  // Called at a negedge while the DUT is in IDLE with requests already driven.
  // Plays the controller: answers the call `delay` cycles after it appears,
  // optionally pulsing foreign done bits early. Returns at the IDLE negedge.
  task automatic serve(input int delay, input logic [DATA_W-1:0] rd,
                       input logic [2:0] stray, input bit hold_disp);
    int                win;
    int                lat;
    int                hold_bad;
    bit                seen;
    logic [2:0]        exp_call;
    logic [ADDR_W-1:0] exp_addr;

    win = model_pick(bus_if.disp_req, bus_if.cam_req, bus_if.aux_req);
    starve_cam_m = (bus_if.cam_req && win != 2) ?
                   ((starve_cam_m < STARVE_MAX) ? starve_cam_m + 1 : STARVE_MAX) : 0;
    starve_aux_m = (bus_if.aux_req && win != 3) ?
                   ((starve_aux_m < STARVE_MAX) ? starve_aux_m + 1 : STARVE_MAX) : 0;
    case (win)
      1: begin exp_call = 3'b100; exp_addr = bus_if.disp_addr; end
      2: begin exp_call = 3'b010; exp_addr = bus_if.cam_addr; wdata_m = bus_if.cam_wdata; end
      3: begin exp_call = 3'b001; exp_addr = bus_if.aux_addr; end
      default: begin exp_call = 3'b000; exp_addr = '0; end
    endcase

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus_if.mem_call != 3'b000) seen = 1'b1;
    end
    check("call_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("call_latency", 64'(lat),                64'd2);
    check("mem_call",     64'(bus_if.mem_call),    64'(exp_call));
    check("mem_addr",     64'(bus_if.mem_addr),    64'(exp_addr));
    check("mem_wdata",    64'(bus_if.mem_wdata),   64'(wdata_m));
    check("grant_id",     64'(bus_if.grant_id),    64'(win));
    check("busy_issue",   64'(bus_if.busy),        64'd1);
    check("aux_rdata_kept", 64'(bus_if.aux_rdata), 64'(rdata_m));

    hold_bad = 0;
    for (int i = 1; i <= delay; i++) begin
      @(negedge clk);
      if (bus_if.mem_call !== exp_call || bus_if.grant_id !== 2'(win) ||
          bus_if.busy !== 1'b1 || dones() !== 3'b000 ||
          bus_if.mem_addr !== exp_addr || bus_if.mem_wdata !== wdata_m)
        hold_bad++;
      bus_if.mem_done  = (i == 1 && delay >= 3) ? (stray & ~exp_call) : 3'b000;
      bus_if.mem_rdata = DATA_W'($urandom);
    end
    check("wait_hold_bad_cycles", 64'(hold_bad), 64'd0);
    bus_if.mem_done  = exp_call;
    bus_if.mem_rdata = rd;

    @(negedge clk);
    bus_if.mem_done  = 3'b000;
    bus_if.mem_rdata = ~rd;
    check("done_pulse",    64'(dones()),         64'(exp_call));
    check("call_cleared",  64'(bus_if.mem_call), 64'd0);
    check("grant_id_ack",  64'(bus_if.grant_id), 64'(win));
    check("busy_ack",      64'(bus_if.busy),     64'd1);
    if (win == 3) begin
      rdata_m = rd;
      check("aux_rdata", 64'(bus_if.aux_rdata), 64'(rd));
    end
    case (win)
      1: if (!hold_disp) bus_if.disp_req = 1'b0;
      2: bus_if.cam_req = 1'b0;
      3: bus_if.aux_req = 1'b0;
      default: ;
    endcase

    @(negedge clk);
    check("done_single",   64'(dones()),         64'd0);
    check("busy_idle",     64'(bus_if.busy),     64'd0);
    check("grant_id_idle", 64'(bus_if.grant_id), 64'd0);
  endtask

  initial begin
    bus_if.disp_req  = 1'b0;
    bus_if.cam_req   = 1'b0;
    bus_if.aux_req   = 1'b0;
    bus_if.disp_addr = '0;
    bus_if.cam_addr  = '0;
    bus_if.aux_addr  = '0;
    bus_if.cam_wdata = '0;
    bus_if.mem_done  = 3'b000;
    bus_if.mem_rdata = '0;

    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single camera write.
    bus_if.cam_req   = 1'b1;
    bus_if.cam_addr  = 24'h000123;
    bus_if.cam_wdata = 16'hBEEF;
    serve(5, 16'h0000, 3'b000, 1'b0);

    // Display and aux together: display first, then aux back to back.
    bus_if.disp_req  = 1'b1;
    bus_if.disp_addr = 24'h200000;
    bus_if.aux_req   = 1'b1;
    bus_if.aux_addr  = 24'h000ABC;
    serve(3, 16'h0000, 3'b000, 1'b0);
    serve(4, 16'h5A5A, 3'b000, 1'b0);

    // Display held continuously while cam waits: cam wins the 9th arbitration.
    bus_if.disp_req  = 1'b1;
    bus_if.disp_addr = 24'h100000;
    bus_if.cam_req   = 1'b1;
    bus_if.cam_addr  = 24'h000456;
    bus_if.cam_wdata = 16'h0F0F;
    for (int n = 0; n < 9; n++) serve(2, 16'h0000, 3'b000, 1'b1);
    check("starve_cam_cleared", 64'(dut.starve_cam_q), 64'(starve_cam_m));
    serve(2, 16'h0000, 3'b000, 1'b0);

    // Refresh-length stall.
    bus_if.disp_req  = 1'b1;
    bus_if.disp_addr = 24'h3F0000;
    serve(760, 16'h0000, 3'b000, 1'b0);

    // Stray read-done while cam waits.
    bus_if.cam_req   = 1'b1;
    bus_if.cam_addr  = 24'h000777;
    bus_if.cam_wdata = 16'h5555;
    serve(5, 16'h0000, 3'b001, 1'b0);

    // Reset during WAIT aborts at once.
    bus_if.cam_req   = 1'b1;
    bus_if.cam_addr  = 24'h0ABCDE;
    bus_if.cam_wdata = 16'h1234;
    repeat (3) @(negedge clk);
    check("pre_reset_call", 64'(bus_if.mem_call), 64'h2);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    bus_if.cam_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    starve_cam_m = 0;
    starve_aux_m = 0;
    wdata_m      = '0;
    rdata_m      = '0;
    @(negedge clk);
    bus_if.aux_req  = 1'b1;
    bus_if.aux_addr = 24'h00C0DE;
    serve(4, 16'hC3C3, 3'b000, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 30; n++) begin
      if (!bus_if.disp_req && $urandom_range(0, 1) == 1) begin
        bus_if.disp_req  = 1'b1;
        bus_if.disp_addr = ADDR_W'($urandom);
      end
      if (!bus_if.cam_req && $urandom_range(0, 1) == 1) begin
        bus_if.cam_req   = 1'b1;
        bus_if.cam_addr  = ADDR_W'($urandom);
        bus_if.cam_wdata = DATA_W'($urandom);
      end
      if (!bus_if.aux_req && $urandom_range(0, 1) == 1) begin
        bus_if.aux_req  = 1'b1;
        bus_if.aux_addr = ADDR_W'($urandom);
      end
      if (!bus_if.disp_req && !bus_if.cam_req && !bus_if.aux_req) begin
        bus_if.aux_req  = 1'b1;
        bus_if.aux_addr = ADDR_W'($urandom);
      end
      serve(int'($urandom_range(1, 8)), DATA_W'($urandom),
            3'($urandom_range(0, 7)), 1'b0);
    end

    bus_if.disp_req = 1'b0;
    bus_if.cam_req  = 1'b0;
    bus_if.aux_req  = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle", 64'(bus_if.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
